dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage: accepts one load/store,
// inserts WAIT wait states, then returns a single-cycle response.
module dmem_responder #(
    parameter int WAIT = 2,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          busy
);

    localparam logic [1:0] stIdle = 2'd0;
    localparam logic [1:0] stWait = 2'd1;
    localparam logic [1:0] stResp = 2'd2;

    localparam logic [3:0] waitLoad = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    waitCnt;
    logic          capWrite;
    logic [AW-1:0] capAddr;
    logic [31:0]   capWdata;

    // Storage is deliberately left without a reset so it can be preloaded
    // hierarchically through <instance>.mem in simulation and survives rst.
    logic [31:0]   mem [2**AW];

    logic          accept;
    logic          enterResp;
    logic          effWrite;
    logic [AW-1:0] effAddr;
    logic [31:0]   effWdata;

    assign req_ready = (state == stIdle) && !rst;
    assign busy      = (state != stIdle);
    assign rsp_valid = (state == stResp);
    assign accept    = req_ready && req_valid;

    // With WAIT=0 the acceptance edge is also the edge entering RESP, so the
    // live request inputs are used there instead of the not-yet-loaded capture.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        effWrite  = capWrite;
        effAddr   = capAddr;
        effWdata  = capWdata;
        enterResp = 1'b0;
        if (state == stIdle) begin
            effWrite  = req_write;
            effAddr   = req_addr;
            effWdata  = req_wdata;
            enterResp = accept && (WAIT == 0);
        end else if (state == stWait) begin
            enterResp = (waitCnt == 4'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= stIdle;
            waitCnt   <= 4'd0;
            rsp_rdata <= 32'd0;
            capWrite  <= 1'b0;
            capAddr   <= '0;
            capWdata  <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                stIdle: begin
                    if (accept) begin
                        capWrite <= req_write;
                        capAddr  <= req_addr;
                        capWdata <= req_wdata;
                        if (WAIT == 0) begin
                            state <= stResp;
                        end else begin
                            state   <= stWait;
                            waitCnt <= waitLoad;
                        end
                    end
                end
                stWait: begin
                    if (waitCnt == 4'd0) state <= stResp;
                    else                 waitCnt <= waitCnt - 4'd1;
                end
                stResp:  state <= stIdle;
                default: state <= stIdle;
            endcase
            if (enterResp) rsp_rdata <= effWrite ? effWdata : mem[effAddr];
        end
    end

    always_ff @(posedge clk) begin
        if (enterResp && effWrite) mem[effAddr] <= effWdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT = 2, 0, 3) are
// exercised one at a time; responses are matched against a queue by data and cycle.
module tb_dmem_responder;

    localparam int NI = 3;
    localparam int WAITS [NI] = '{2, 0, 3};

    logic        clk = 1'b0;
    logic        rst      [NI];
    logic        reqValid [NI];
    logic        reqWrite [NI];
    logic [6:0]  reqAddr  [NI];
    logic [31:0] reqWdata [NI];
    logic        reqReady [NI];
    logic        rspValid [NI];
    logic [31:0] rspRdata [NI];
    logic        busy     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gInst
        dmem_responder #(.WAIT(WAITS[g]), .AW(7)) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (reqValid[g]),
            .req_write (reqWrite[g]),
            .req_addr  (reqAddr[g]),
            .req_wdata (reqWdata[g]),
            .req_ready (reqReady[g]),
            .rsp_valid (rspValid[g]),
            .rsp_rdata (rspRdata[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];
    logic [31:0] lastData [NI];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: sampled just after the falling edge, after any driver updates.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (rst[i]) begin
                    check("rst_ready", 32'(reqReady[i]), 32'd0);
                    check("rst_busy", 32'(busy[i]), 32'd0);
                    check("rst_rspvalid", 32'(rspValid[i]), 32'd0);
                    check("rst_rdata", rspRdata[i], 32'd0);
                    lastData[i] = 32'd0;
                end else if (rspValid[i]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'(rspValid[i]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_cycle", 32'(cyc), 32'(e.due));
                        check("rsp_rdata", rspRdata[i], e.data);
                        lastData[i] = e.data;
                    end
                end else begin
                    check("rdata_hold", rspRdata[i], lastData[i]);
                end
            end
        end
    end

    task automatic waitReady(input int i);
        int n = 0;
        while (!reqReady[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady[i]) check("ready_timeout", 32'(reqReady[i]), 32'd1);
    endtask

    task automatic scramble(input int i);
        reqWrite[i] = 1'($urandom);
        reqAddr[i]  = 7'($urandom);
        reqWdata[i] = $urandom;
    endtask

    // Drives one request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input int i, input logic wr, input logic [6:0] a,
                         input logic [31:0] d, input bit expectRsp, output int acc);
        int key;
        waitReady(i);
        reqValid[i] = 1'b1;
        reqWrite[i] = wr;
        reqAddr[i]  = a;
        reqWdata[i] = d;
        acc = cyc + 1;
        key = i * 256 + int'(a);
        if (expectRsp) begin
            if (wr) mdl[key] = d;
            sb.push_back('{inst: i, data: (mdl.exists(key) ? mdl[key] : 32'd0), due: acc + WAITS[i]});
        end
        @(negedge clk);
        check("acc_busy", 32'(busy[i]), 32'd1);
        check("acc_ready", 32'(reqReady[i]), 32'd0);
        reqValid[i] = 1'b0;
        scramble(i);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulseReset(input int i);
        rst[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst[i] = 1'b0;
        #1;
        check("ready_after_rst", 32'(reqReady[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int i = 0; i < NI; i++) begin
            rst[i]      = 1'b1;
            reqValid[i] = 1'b0;
            reqWrite[i] = 1'b0;
            reqAddr[i]  = 7'd0;
            reqWdata[i] = 32'd0;
        end
        gInst[0].dut.mem[0] <= 32'hCAFEF00D;
        mdl[0] = 32'hCAFEF00D;

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) check("ready_after_rst", 32'(reqReady[i]), 32'd1);

        // WAIT=2 store then load of the same word
        issue(0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, acc);
        while (cyc < acc + 3) @(negedge clk);
        check("ready_after_resp", 32'(reqReady[0]), 32'd1);
        issue(0, 1'b0, 7'd5, 32'd0, 1'b1, acc);
        drain();

        // WAIT=0 back-to-back traffic at the top and bottom of the address space
        issue(1, 1'b1, 7'd0,   32'h0BADC0DE, 1'b1, acc);
        issue(1, 1'b1, 7'd127, 32'h12345678, 1'b1, acc);
        issue(1, 1'b0, 7'd127, 32'd0,        1'b1, acc);
        issue(1, 1'b0, 7'd0,   32'd0,        1'b1, acc);
        issue(1, 1'b1, 7'd127, 32'h87654321, 1'b1, acc);
        issue(1, 1'b0, 7'd127, 32'd0,        1'b1, acc);
        drain();

        // WAIT=2 with req_valid held and request inputs changing while busy
        waitReady(0);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 7'd20;
        reqWdata[0] = 32'h5A5A0001;
        acc = cyc + 1;
        mdl[20] = 32'h5A5A0001;
        sb.push_back('{inst: 0, data: 32'h5A5A0001, due: acc + WAITS[0]});
        for (int k = 0; k <= WAITS[0]; k++) begin
            @(negedge clk);
            check("hold_ready", 32'(reqReady[0]), 32'd0);
            if (k == WAITS[0]) reqValid[0] = 1'b0;
            else               scramble(0);
        end
        drain();
        issue(0, 1'b0, 7'd20, 32'd0, 1'b1, acc);
        drain();

        // WAIT=3 store aborted by reset one cycle after acceptance
        issue(2, 1'b1, 7'd9, 32'h01010101, 1'b1, acc);
        drain();
        issue(2, 1'b1, 7'd9, 32'hAAAA5555, 1'b0, acc);
        rst[2] = 1'b1;
        #1;
        check("abort_busy", 32'(busy[2]), 32'd0);
        check("abort_rspvalid", 32'(rspValid[2]), 32'd0);
        check("abort_rdata", rspRdata[2], 32'd0);
        check("abort_ready", 32'(reqReady[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        #1;
        check("ready_after_abort", 32'(reqReady[2]), 32'd1);
        repeat (6) @(negedge clk);
        issue(2, 1'b0, 7'd9, 32'd0, 1'b1, acc);
        drain();

        // Preloaded word survives reset
        pulseReset(0);
        issue(0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
